playseq_motor_n: RTL and testbench
==================================

Name: playseq_motor_n

Overview:
Parametrised, self-contained sequence-game engine: N-button generalisation of the PlaySeq datapath with its own control FSM. It holds a writable pattern memory and plays a growing prefix of it on the LEDs (preview). It then checks the player's presses against that prefix under a per-press timeout and keeps saturating win/loss counters. It sits between the debounced button inputs and the LED/7-segment debug layer, replacing the fixed 4-button, 16-entry, ROM-based datapath.

Parameters:
N, 4, number of buttons/LEDs (one-hot codes, width N)
AW, 4, address width; memory depth 2**AW
SEQ_INICIAL, 1, length of the first round (1..2**AW)
T_LED, 500, cycles per LED on phase and per off phase during preview
T_JOGADA, 5000, cycles allowed between accepted presses
SW, 4, width of ganhos/perdas counters

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
iniciar  in  1  level; start/restart a game (sampled only in OCIOSO, GANHOU, PERDEU)
botoes  in  N  debounced button levels
comprimento  in  AW+1  final sequence length, sampled on accepted iniciar
escreve  in  1  memory write enable (honoured only in OCIOSO)
end_escrita  in  AW  write address
dado_escrita  in  N  write data
leds  out  N  LED drive
jogando  out  1  high from preview start until GANHOU/PERDEU
ganhou  out  1  high while in GANHOU
perdeu  out  1  high while in PERDEU
timeout  out  1  high while in PERDEU if the loss was a timeout
ganhos  out  SW  games won, saturating
perdas  out  SW  games lost, saturating
db_estado  out  4  current state code
db_endereco  out  AW  current memory address
db_limite  out  AW+1  current round length

Behaviour:
- Reset: state OCIOSO. leds=0; jogando, ganhou, perdeu and timeout=0; ganhos=perdas=0; addresses and limit cleared. Memory contents are not cleared.
- Memory: 2**AW x N register array. Synchronous write when escreve is high and state is OCIOSO; writes are ignored in any other state. Read is combinational at the current address.
- Length: comprimento is registered on iniciar. A value of 0 loads 1; a value above 2**AW loads 2**AW. The limit starts at min(SEQ_INICIAL, final length).
- States and transitions:
  - OCIOSO: on iniciar go to PREV_LIGA, with address=0 and the limit loaded. If escreve and iniciar are high in the same cycle, the write completes and the game starts.
  - PREV_LIGA: leds=mem[address] for T_LED cycles, then go to PREV_DESLIGA.
  - PREV_DESLIGA: leds=0 for T_LED cycles. Then, if address==limit-1, go to ESPERA with address=0 and the timer loaded. Otherwise increment address and go to PREV_LIGA.
  - ESPERA: leds=botoes. A press is the rising edge of |botoes, tracked by an internal edge detector that is cleared on entry to PREV_LIGA.
    - On a press: register botoes and go to COMPARA.
    - If the timer expires with no press: set timeout and go to PERDEU.
    - Press and expiry in the same cycle: the press wins.
  - COMPARA: one cycle. The press matches if the registered value equals mem[address] and is exactly one-hot; a multi-hot press is always wrong.
    - Wrong: go to PERDEU.
    - Right, and address<limit-1: increment address, reload the timer, go to ESPERA.
    - Right, and address==limit-1: if limit==final length go to GANHOU; otherwise increment limit, set address=0, go to PREV_LIGA.
  - GANHOU / PERDEU: ganhos or perdas increments once on entry, holding at 2**SW-1. On iniciar, start a new game exactly as from OCIOSO. The counters are not cleared.
- Timer: a single down-counter loaded with T_LED-1 or T_JOGADA-1; it expires on the cycle it reads 0. In ESPERA it reloads on every press.
- jogando=1 in PREV_LIGA, PREV_DESLIGA, ESPERA and COMPARA.
- Latency: a press edge reaches COMPARA on the next cycle; the outcome state is entered on the cycle after that.
- Reset asserted mid-game returns immediately to OCIOSO and discards all progress.

Decomposition:
- Package playseq_pkg holds the state encoding (4-bit localparams: OCIOSO=0, PREV_LIGA=1, PREV_DESLIGA=2, ESPERA=3, COMPARA=4, GANHOU=5, PERDEU=6) and a one-hot check function.
- Sub-module playseq_temporizador: a loadable down-counter with parameter width, ports clock, reset, carrega, valor, conta, fim.
- The FSM, memory, edge detector and counters live in the top module.

Test Plan:
All scenarios use N=4, AW=3, SEQ_INICIAL=1, T_LED=4, T_JOGADA=20.
1. Write mem=[1,2,4,8], comprimento=2, iniciar: preview shows leds=1 for 4 cycles, then 0 for 4. Press 1 -> preview 1,2. Press 1,2 -> ganhou=1, ganhos=1.
2. Same memory, round 2, press 1 then 4 -> perdeu=1, timeout=0, perdas=1, jogando=0 on the cycle after COMPARA.
3. Enter ESPERA and press nothing for 20 cycles -> perdeu=1, timeout=1. With the press edge on the expiry cycle instead, the game continues.
4. Press 4'b0011 where mem=3 -> loss (multi-hot).
5. comprimento=0 -> single-element game. comprimento=15 -> limit clamps to 8. escreve during preview leaves the memory unchanged.
6. Force 16 wins with SW=4 -> ganhos holds at 15. Assert reset mid-preview -> leds=0, OCIOSO, counters=0.

Source files
------------

// File: rtl/playseq_pkg.sv
// Shared definitions for the sequence-game engine: state encoding and a
// one-hot test used when judging a player's press.
package playseq_pkg;

    // state        | meaning
    // OCIOSO       | idle, memory writable, waiting for iniciar
    // PREV_LIGA    | preview: LED pattern of the current address lit
    // PREV_DESLIGA | preview: LEDs dark between steps
    // ESPERA       | waiting for the player's next press (timed)
    // COMPARA      | one-cycle check of the registered press
    // GANHOU       | game won, waiting for a restart
    // PERDEU       | game lost (wrong press or timeout)
    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        PREV_LIGA    = 4'd1,
        PREV_DESLIGA = 4'd2,
        ESPERA       = 4'd3,
        COMPARA      = 4'd4,
        GANHOU       = 4'd5,
        PERDEU       = 4'd6
    } estado_t;

    // True when exactly one bit is set; callers zero-extend to 64 bits.
    function automatic logic eh_one_hot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/playseq_temporizador.sv
// Loadable down-counter; fim is high on every cycle the count reads zero.
module playseq_temporizador #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic [W-1:0] valor,
    input  logic         conta,
    output logic         fim
);

    logic [W-1:0] contagem;

    // Load has priority; counting stops at zero so fim stays asserted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= valor;
        end else if (conta && (contagem != '0)) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign fim = (contagem == '0);

endmodule

// File: rtl/playseq_motor_n.sv
// N-button sequence-game engine: pattern memory, preview playback, press
// checking under a per-press timeout, saturating win/loss counters.
module playseq_motor_n
    import playseq_pkg::*;
#(
    parameter int N           = 4,
    parameter int AW          = 4,
    parameter int SEQ_INICIAL = 1,
    parameter int T_LED       = 500,
    parameter int T_JOGADA    = 5000,
    parameter int SW          = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic [N-1:0]  botoes,
    input  logic [AW:0]   comprimento,
    input  logic          escreve,
    input  logic [AW-1:0] end_escrita,
    input  logic [N-1:0]  dado_escrita,
    output logic [N-1:0]  leds,
    output logic          jogando,
    output logic          ganhou,
    output logic          perdeu,
    output logic          timeout,
    output logic [SW-1:0] ganhos,
    output logic [SW-1:0] perdas,
    output logic [3:0]    db_estado,
    output logic [AW-1:0] db_endereco,
    output logic [AW:0]   db_limite
);

    localparam int LW    = AW + 1;
    localparam int DEPTH = 2 ** AW;
    localparam int T_MAX = (T_LED > T_JOGADA) ? T_LED : T_JOGADA;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] VAL_LED    = TW'(T_LED - 1);
    localparam logic [TW-1:0] VAL_JOGADA = TW'(T_JOGADA - 1);

    estado_t       estado, estado_prox;
    logic [N-1:0]  mem [DEPTH];
    logic [N-1:0]  mem_atual;
    logic [AW-1:0] endereco;
    logic [LW-1:0] limite, final_len, comp_lim, lim_ini;
    logic [N-1:0]  botoes_reg;
    logic          btn_ant, pressao, acerto, ultimo;
    logic          timeout_r;
    logic [SW-1:0] ganhos_r, perdas_r;

    logic          carrega_t, conta_t, fim_t;
    logic [TW-1:0] valor_t;
    logic          inicia, end_zera, end_inc, lim_inc, edge_limpa, captura;
    logic          marca_timeout, inc_ganhos, inc_perdas;

    playseq_temporizador #(.W(TW)) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .carrega (carrega_t),
        .valor   (valor_t),
        .conta   (conta_t),
        .fim     (fim_t)
    );

    // Clamp the requested length into 1..DEPTH and pick the first round length.
    always_comb begin
        comp_lim = comprimento;
        if (comprimento == '0) begin
            comp_lim = LW'(1);
        end else if (comprimento > LW'(DEPTH)) begin
            comp_lim = LW'(DEPTH);
        end
        lim_ini = (LW'(SEQ_INICIAL) < comp_lim) ? LW'(SEQ_INICIAL) : comp_lim;
    end

    assign mem_atual = mem[endereco];
    assign pressao   = (|botoes) && !btn_ant;
    assign ultimo    = ({1'b0, endereco} == (limite - 1'b1));
    assign acerto    = (botoes_reg == mem_atual) && eh_one_hot(64'(botoes_reg));

    // Pattern memory: writable only while idle, no reset on contents.
    always_ff @(posedge clock) begin
        if (escreve && (estado == OCIOSO)) begin
            mem[end_escrita] <= dado_escrita;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next state, datapath controls and LED drive.
    always_comb begin
        estado_prox   = estado;
        carrega_t     = 1'b0;
        valor_t       = VAL_LED;
        conta_t       = 1'b0;
        inicia        = 1'b0;
        end_zera      = 1'b0;
        end_inc       = 1'b0;
        lim_inc       = 1'b0;
        edge_limpa    = 1'b0;
        captura       = 1'b0;
        marca_timeout = 1'b0;
        inc_ganhos    = 1'b0;
        inc_perdas    = 1'b0;
        leds          = '0;
        case (estado)
            OCIOSO, GANHOU, PERDEU: begin
                if (iniciar) begin
                    estado_prox = PREV_LIGA;
                    inicia      = 1'b1;
                    carrega_t   = 1'b1;
                end
            end
            PREV_LIGA: begin
                leds    = mem_atual;
                conta_t = 1'b1;
                if (fim_t) begin
                    estado_prox = PREV_DESLIGA;
                    carrega_t   = 1'b1;
                end
            end
            PREV_DESLIGA: begin
                conta_t = 1'b1;
                if (fim_t) begin
                    carrega_t = 1'b1;
                    if (ultimo) begin
                        estado_prox = ESPERA;
                        end_zera    = 1'b1;
                        valor_t     = VAL_JOGADA;
                    end else begin
                        estado_prox = PREV_LIGA;
                        end_inc     = 1'b1;
                        edge_limpa  = 1'b1;
                    end
                end
            end
            ESPERA: begin
                leds    = botoes;
                conta_t = 1'b1;
                // A press on the expiry cycle still counts.
                if (pressao) begin
                    estado_prox = COMPARA;
                    captura     = 1'b1;
                    carrega_t   = 1'b1;
                    valor_t     = VAL_JOGADA;
                end else if (fim_t) begin
                    estado_prox   = PERDEU;
                    marca_timeout = 1'b1;
                    inc_perdas    = 1'b1;
                end
            end
            COMPARA: begin
                if (!acerto) begin
                    estado_prox = PERDEU;
                    inc_perdas  = 1'b1;
                end else if (!ultimo) begin
                    estado_prox = ESPERA;
                    end_inc     = 1'b1;
                    carrega_t   = 1'b1;
                    valor_t     = VAL_JOGADA;
                end else if (limite == final_len) begin
                    estado_prox = GANHOU;
                    inc_ganhos  = 1'b1;
                end else begin
                    estado_prox = PREV_LIGA;
                    lim_inc     = 1'b1;
                    end_zera    = 1'b1;
                    carrega_t   = 1'b1;
                    edge_limpa  = 1'b1;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // Address, round limit, captured press, edge detector, loss cause, counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco   <= '0;
            limite     <= '0;
            final_len  <= '0;
            botoes_reg <= '0;
            btn_ant    <= 1'b0;
            timeout_r  <= 1'b0;
            ganhos_r   <= '0;
            perdas_r   <= '0;
        end else begin
            if (inicia) begin
                endereco  <= '0;
                limite    <= lim_ini;
                final_len <= comp_lim;
                timeout_r <= 1'b0;
            end else begin
                if (end_zera) begin
                    endereco <= '0;
                end else if (end_inc) begin
                    endereco <= endereco + 1'b1;
                end
                if (lim_inc) begin
                    limite <= limite + 1'b1;
                end
                if (marca_timeout) begin
                    timeout_r <= 1'b1;
                end
            end
            if (captura) begin
                botoes_reg <= botoes;
            end
            btn_ant <= (inicia || edge_limpa) ? 1'b0 : (|botoes);
            if (inc_ganhos && (ganhos_r != '1)) begin
                ganhos_r <= ganhos_r + 1'b1;
            end
            if (inc_perdas && (perdas_r != '1)) begin
                perdas_r <= perdas_r + 1'b1;
            end
        end
    end

    assign jogando     = (estado == PREV_LIGA) || (estado == PREV_DESLIGA) ||
                         (estado == ESPERA) || (estado == COMPARA);
    assign ganhou      = (estado == GANHOU);
    assign perdeu      = (estado == PERDEU);
    assign timeout     = (estado == PERDEU) && timeout_r;
    assign ganhos      = ganhos_r;
    assign perdas      = perdas_r;
    assign db_estado   = estado;
    assign db_endereco = endereco;
    assign db_limite   = limite;

endmodule

// File: tb/tb_playseq_motor_n.sv
// Directed bench for playseq_motor_n with N=4, AW=3, T_LED=4, T_JOGADA=20.
module tb_playseq_motor_n;

    localparam int ST_OCIOSO  = 0;
    localparam int ST_LIGA    = 1;
    localparam int ST_DESLIGA = 2;
    localparam int ST_ESPERA  = 3;
    localparam int ST_COMPARA = 4;
    localparam int ST_GANHOU  = 5;
    localparam int ST_PERDEU  = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] botoes = 4'd0;
    logic [3:0] comprimento = 4'd0;
    logic       escreve = 1'b0;
    logic [2:0] end_escrita = 3'd0;
    logic [3:0] dado_escrita = 4'd0;
    logic [3:0] leds;
    logic       jogando, ganhou, perdeu, timeout;
    logic [3:0] ganhos, perdas;
    logic [3:0] db_estado;
    logic [2:0] db_endereco;
    logic [3:0] db_limite;

    int total = 0;
    int bad = 0;
    logic [3:0] tb_mem [8];

    always #5 clock = ~clock;

    playseq_motor_n #(
        .N(4), .AW(3), .SEQ_INICIAL(1), .T_LED(4), .T_JOGADA(20), .SW(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .botoes       (botoes),
        .comprimento  (comprimento),
        .escreve      (escreve),
        .end_escrita  (end_escrita),
        .dado_escrita (dado_escrita),
        .leds         (leds),
        .jogando      (jogando),
        .ganhou       (ganhou),
        .perdeu       (perdeu),
        .timeout      (timeout),
        .ganhos       (ganhos),
        .perdas       (perdas),
        .db_estado    (db_estado),
        .db_endereco  (db_endereco),
        .db_limite    (db_limite)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [3:0] comp);
        comprimento = comp;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("start_state", 32'(db_estado), ST_LIGA);
        chk("start_jogando", 32'(jogando), 1);
    endtask

    // Called on the first PREV_LIGA cycle; returns on the first ESPERA cycle.
    task automatic check_preview(input int len);
        for (int k = 0; k < len; k++) begin
            chk("prev_on_state", 32'(db_estado), ST_LIGA);
            for (int c = 0; c < 4; c++) begin
                chk("prev_on_leds", 32'(leds), 32'(tb_mem[k]));
                step();
            end
            chk("prev_off_state", 32'(db_estado), ST_DESLIGA);
            for (int c = 0; c < 4; c++) begin
                chk("prev_off_leds", 32'(leds), 0);
                step();
            end
        end
        chk("prev_end_espera", 32'(db_estado), ST_ESPERA);
    endtask

    // Press in ESPERA; returns on the outcome cycle after COMPARA.
    task automatic press(input logic [3:0] v);
        botoes = v;
        step();
        chk("press_compara", 32'(db_estado), ST_COMPARA);
        botoes = 4'd0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_state", 32'(db_estado), ST_OCIOSO);
        chk("rst_leds", 32'(leds), 0);
        chk("rst_flags", 32'({jogando, ganhou, perdeu, timeout}), 0);
        chk("rst_counters", 32'({ganhos, perdas}), 0);
        chk("rst_addr_lim", 32'({db_endereco, db_limite}), 0);
        @(negedge clock);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            tb_mem[i] = 4'(1 << (i % 4));
            escreve = 1'b1;
            end_escrita = 3'(i);
            dado_escrita = tb_mem[i];
            step();
        end
        escreve = 1'b0;

        // Two-round win.
        start(4'd2);
        chk("a_lim1", 32'(db_limite), 1);
        check_preview(1);
        press(4'd1);
        chk("a_next_round", 32'(db_estado), ST_LIGA);
        chk("a_lim2", 32'(db_limite), 2);
        check_preview(2);
        press(4'd1);
        chk("a_mid_espera", 32'(db_estado), ST_ESPERA);
        chk("a_addr1", 32'(db_endereco), 1);
        press(4'd2);
        chk("a_ganhou_state", 32'(db_estado), ST_GANHOU);
        chk("a_ganhou", 32'(ganhou), 1);
        chk("a_ganhos", 32'(ganhos), 1);
        chk("a_jogando", 32'(jogando), 0);

        // Wrong press in round 2.
        start(4'd2);
        check_preview(1);
        press(4'd1);
        check_preview(2);
        press(4'd1);
        press(4'd4);
        chk("b_perdeu", 32'(perdeu), 1);
        chk("b_timeout", 32'(timeout), 0);
        chk("b_perdas", 32'(perdas), 1);
        chk("b_jogando", 32'(jogando), 0);
        chk("b_ganhos", 32'(ganhos), 1);

        // Timeout after 20 idle cycles.
        start(4'd1);
        check_preview(1);
        repeat (19) step();
        chk("c_still_espera", 32'(db_estado), ST_ESPERA);
        step();
        chk("c_perdeu", 32'(db_estado), ST_PERDEU);
        chk("c_timeout", 32'(timeout), 1);
        chk("c_perdas", 32'(perdas), 2);

        // Press on the expiry cycle wins over the timeout.
        start(4'd1);
        chk("c_timeout_clr", 32'(timeout), 0);
        check_preview(1);
        repeat (19) step();
        botoes = 4'd1;
        step();
        chk("c_edge_compara", 32'(db_estado), ST_COMPARA);
        botoes = 4'd0;
        step();
        chk("c_edge_ganhou", 32'(db_estado), ST_GANHOU);
        chk("c_edge_ganhos", 32'(ganhos), 2);

        // comprimento=0 plays a single element; writes during preview ignored.
        start(4'd0);
        chk("d_lim", 32'(db_limite), 1);
        escreve = 1'b1;
        end_escrita = 3'd0;
        dado_escrita = 4'd8;
        step();
        escreve = 1'b0;
        chk("d_mem_kept", 32'(leds), 1);
        repeat (2) step();
        chk("d_liga", 32'(db_estado), ST_LIGA);
        step();
        chk("d_desliga", 32'(db_estado), ST_DESLIGA);
        repeat (4) step();
        chk("d_espera", 32'(db_estado), ST_ESPERA);
        press(4'd1);
        chk("d_ganhou", 32'(db_estado), ST_GANHOU);
        chk("d_ganhos", 32'(ganhos), 3);

        // comprimento=15 clamps to 8 rounds.
        start(4'd15);
        for (int r = 1; r <= 8; r++) begin
            chk("e_lim", 32'(db_limite), 32'(r));
            check_preview(r);
            for (int k = 0; k < r; k++) begin
                press(tb_mem[k]);
                if (k < r - 1)
                    chk("e_espera", 32'(db_estado), ST_ESPERA);
                else if (r < 8)
                    chk("e_next_round", 32'(db_estado), ST_LIGA);
                else
                    chk("e_ganhou", 32'(db_estado), ST_GANHOU);
            end
        end
        chk("e_ganhos", 32'(ganhos), 4);

        // Reset, then saturate the win counter.
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("r_counters", 32'({ganhos, perdas}), 0);
        chk("r_state", 32'(db_estado), ST_OCIOSO);
        @(negedge clock);
        reset = 1'b1;
        step();
        for (int g = 0; g < 16; g++) begin
            start(4'd1);
            check_preview(1);
            press(4'd1);
            chk("f_ganhou", 32'(db_estado), ST_GANHOU);
        end
        chk("f_ganhos_sat", 32'(ganhos), 15);
        chk("f_perdas", 32'(perdas), 0);

        // Asynchronous reset mid-preview.
        start(4'd2);
        repeat (2) step();
        reset = 1'b0;
        #1;
        chk("g_leds", 32'(leds), 0);
        chk("g_state", 32'(db_estado), ST_OCIOSO);
        chk("g_counters", 32'({ganhos, perdas}), 0);
        chk("g_jogando", 32'(jogando), 0);
        chk("g_lim", 32'(db_limite), 0);
        @(negedge clock);
        reset = 1'b1;
        step();

        // Multi-hot press against a multi-hot memory entry is a loss.
        tb_mem[0] = 4'b0011;
        escreve = 1'b1;
        end_escrita = 3'd0;
        dado_escrita = 4'b0011;
        step();
        escreve = 1'b0;
        start(4'd1);
        check_preview(1);
        press(4'b0011);
        chk("h_perdeu", 32'(db_estado), ST_PERDEU);
        chk("h_timeout", 32'(timeout), 0);
        chk("h_perdas", 32'(perdas), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
